// File: rtl/multiplier_array_with_lock_pkg.sv
// multiplier_array_with_lock_pkg: shared request/answer structs and the modular age compare
package multiplier_array_with_lock_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_signed;
        logic [31:0] a;
        logic [31:0] b;
    } mul_req_t;

    typedef struct packed {
        logic        valid;
        logic        busy;
        logic [63:0] result;
    } mul_ans_t;

    localparam int MAX_ID_WIDTH = 32;

    // a is older than b when (a - b) mod 2^width is negative as a signed value
    function automatic logic id_older(input logic [MAX_ID_WIDTH-1:0] a,
                                      input logic [MAX_ID_WIDTH-1:0] b,
                                      input int width);
        logic [MAX_ID_WIDTH-1:0] diff;
        diff = (a - b) >> (width - 1);
        return diff[0];
    endfunction

endpackage

// File: rtl/multiplier_array_with_lock_multiplier_unit.sv
// multiplier_unit: LATENCY-deep pipelined signed/unsigned 32x32 multiplier with kill
module multiplier_unit
    import multiplier_array_with_lock_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     kill,
    input  mul_req_t req,
    output mul_ans_t ans
);

    logic [LATENCY-1:0] vld_q;
    logic [63:0]        prod_q [LATENCY];
    logic [63:0]        prod_d;
    logic               ans_vld_q;
    logic [63:0]        ans_res_q;
    logic [63:0]        ax;
    logic [63:0]        bx;

    // modulo-2^64 product of the extended operands is exact for both signednesses
    assign ax     = {{32{req.is_signed & req.a[31]}}, req.a};
    assign bx     = {{32{req.is_signed & req.b[31]}}, req.b};
    assign prod_d = ax * bx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= '0;
            ans_vld_q <= 1'b0;
            ans_res_q <= '0;
            for (int i = 0; i < LATENCY; i++) prod_q[i] <= '0;
        end else begin
            vld_q     <= kill ? '0 : ((vld_q << 1) | LATENCY'(req.valid));
            ans_vld_q <= vld_q[LATENCY-1] && !kill;
            if (vld_q[LATENCY-1] && !kill) ans_res_q <= prod_q[LATENCY-1];
            prod_q[0] <= prod_d;
            for (int i = 1; i < LATENCY; i++) prod_q[i] <= prod_q[i-1];
        end
    end

    assign ans.valid  = ans_vld_q;
    assign ans.busy   = |vld_q;
    assign ans.result = ans_res_q;

endmodule

// File: rtl/multiplier_array_with_lock.sv
// multiplier_array_with_lock: age-ordered lockable pool of pipelined multipliers shared by ports
module multiplier_array_with_lock
    import multiplier_array_with_lock_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int NUM_PORTS = 8,
    parameter int ID_WIDTH  = 16,
    parameter int LATENCY   = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               lock_req     [NUM_PORTS],
    input  logic [ID_WIDTH-1:0]                lock_id      [NUM_PORTS],
    input  logic                               op_valid     [NUM_PORTS],
    input  logic                               op_signed    [NUM_PORTS],
    input  logic [31:0]                        op_a         [NUM_PORTS],
    input  logic [31:0]                        op_b         [NUM_PORTS],
    output logic                               grant        [NUM_PORTS],
    output logic                               busy         [NUM_PORTS],
    output logic                               result_valid [NUM_PORTS],
    output logic [63:0]                        result       [NUM_PORTS],
    output logic [$clog2(NUM_UNITS+1)-1:0]     units_free
);

    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int UW = $clog2(NUM_UNITS + 1);

    logic [NUM_UNITS-1:0] locked_q, locked_d;
    logic [PW-1:0]        owner_q [NUM_UNITS];
    logic [PW-1:0]        owner_d [NUM_UNITS];
    logic [UW-1:0]        units_free_q, units_free_d;
    logic [NUM_UNITS-1:0] kill;
    logic                 cand [NUM_PORTS];
    logic                 found;
    logic [PW-1:0]        best;
    mul_req_t             req [NUM_UNITS];
    mul_ans_t             ans [NUM_UNITS];

    // a lock dies on flush or when its owner stops requesting; its pipeline dies with it
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            kill[u]          = flush || (locked_q[u] && !lock_req[owner_q[u]]);
            req[u].valid     = locked_q[u] && !kill[u] && !ans[u].busy && op_valid[owner_q[u]];
            req[u].is_signed = op_signed[owner_q[u]];
            req[u].a         = op_a[owner_q[u]];
            req[u].b         = op_b[owner_q[u]];
        end
    end

    // each unit free at cycle start takes the oldest remaining contender
    always_comb begin
        locked_d     = locked_q;
        owner_d      = owner_q;
        units_free_d = UW'(NUM_UNITS);
        found        = 1'b0;
        best         = '0;
        for (int p = 0; p < NUM_PORTS; p++) cand[p] = lock_req[p] && !grant[p] && !flush;
        for (int u = 0; u < NUM_UNITS; u++) if (kill[u]) locked_d[u] = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (!locked_q[u]) begin
                found = 1'b0;
                best  = '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (cand[p] && (!found || id_older(MAX_ID_WIDTH'(lock_id[p]),
                                                       MAX_ID_WIDTH'(lock_id[best]), ID_WIDTH))) begin
                        found = 1'b1;
                        best  = PW'(p);
                    end
                end
                if (found) begin
                    locked_d[u] = 1'b1;
                    owner_d[u]  = best;
                    cand[best]  = 1'b0;
                end
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) units_free_d = units_free_d - UW'(locked_d[u]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked_q     <= '0;
            units_free_q <= UW'(NUM_UNITS);
            for (int u = 0; u < NUM_UNITS; u++) owner_q[u] <= '0;
        end else begin
            locked_q     <= locked_d;
            owner_q      <= owner_d;
            units_free_q <= units_free_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant[p]        = 1'b0;
            busy[p]         = 1'b0;
            result_valid[p] = 1'b0;
            result[p]       = '0;
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (locked_q[u]) begin
                grant[owner_q[u]]        = 1'b1;
                busy[owner_q[u]]         = ans[u].busy;
                result_valid[owner_q[u]] = ans[u].valid;
                result[owner_q[u]]       = ans[u].result;
            end
        end
    end

    assign units_free = units_free_q;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        multiplier_unit #(.LATENCY(LATENCY)) u_mul (
            .clk   (clk),
            .rst_n (rst_n),
            .kill  (kill[u]),
            .req   (req[u]),
            .ans   (ans[u])
        );
    end

endmodule

// File: tb/tb_multiplier_array_with_lock.sv
// tb_multiplier_array_with_lock: directed corner cases, product table and randomized model check
module tb_multiplier_array_with_lock;

    localparam int NU = 2;
    localparam int NP = 8;
    localparam int IW = 16;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          lock_req     [NP];
    logic [IW-1:0] lock_id      [NP];
    logic          op_valid     [NP];
    logic          op_signed    [NP];
    logic [31:0]   op_a         [NP];
    logic [31:0]   op_b         [NP];
    logic          grant        [NP];
    logic          busy         [NP];
    logic          result_valid [NP];
    logic [63:0]   result       [NP];
    logic [1:0]    units_free;

    logic [NP-1:0] gv, bv, rv;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [12];

    bit          m_g    [NP];
    bit          m_busy [NP];
    int          m_cnt  [NP];
    logic [63:0] m_prod [NP];
    bit          e_rv   [NP];
    logic [63:0] e_res  [NP];

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            gv[p] = grant[p];
            bv[p] = busy[p];
            rv[p] = result_valid[p];
        end
    end

    multiplier_array_with_lock #(
        .NUM_UNITS (NU),
        .NUM_PORTS (NP),
        .ID_WIDTH  (IW),
        .LATENCY   (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .lock_req     (lock_req),
        .lock_id      (lock_id),
        .op_valid     (op_valid),
        .op_signed    (op_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .grant        (grant),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .units_free   (units_free)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        for (int p = 0; p < NP; p++) begin
            lock_req[p]  = 1'b0;
            lock_id[p]   = '0;
            op_valid[p]  = 1'b0;
            op_signed[p] = 1'b0;
            op_a[p]      = '0;
            op_b[p]      = '0;
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        return s ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    endfunction

    function automatic bit older(input int p, input int q);
        logic [IW-1:0] d;
        d = lock_id[p] - lock_id[q];
        return $signed(d) < 0;
    endfunction

    // port-level model: who holds a lock, and a countdown per in-flight operation
    task automatic model_step();
        int nfree;
        int best;
        bit pre_g  [NP];
        bit chosen [NP];
        for (int p = 0; p < NP; p++) e_rv[p] = 0;
        if (!rst_n || flush) begin
            for (int p = 0; p < NP; p++) begin
                m_g[p]    = 0;
                m_busy[p] = 0;
            end
        end else begin
            nfree = NU;
            for (int p = 0; p < NP; p++) begin
                pre_g[p]  = m_g[p];
                chosen[p] = 0;
                if (m_g[p]) nfree--;
            end
            for (int p = 0; p < NP; p++) begin
                if (pre_g[p]) begin
                    if (!lock_req[p]) begin
                        m_g[p]    = 0;
                        m_busy[p] = 0;
                    end else if (m_busy[p]) begin
                        m_cnt[p]--;
                        if (m_cnt[p] == 0) begin
                            m_busy[p] = 0;
                            e_rv[p]   = 1;
                            e_res[p]  = m_prod[p];
                        end
                    end else if (op_valid[p]) begin
                        m_busy[p] = 1;
                        m_cnt[p]  = L;
                        m_prod[p] = ref_mul(op_signed[p], op_a[p], op_b[p]);
                    end
                end
            end
            repeat (nfree) begin
                best = -1;
                for (int p = 0; p < NP; p++)
                    if (lock_req[p] && !pre_g[p] && !chosen[p] && (best < 0 || older(p, best))) best = p;
                if (best >= 0) begin
                    chosen[best] = 1;
                    m_g[best]    = 1;
                    m_busy[best] = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int nfree_exp;
        logic [NP-1:0] eg, eb, er;

        vt[0]  = '{1'b1, 32'hFFFF_FFFF, 32'd2,        64'hFFFF_FFFF_FFFF_FFFE};
        vt[1]  = '{1'b0, 32'hFFFF_FFFF, 32'd2,        64'h0000_0001_FFFF_FFFE};
        vt[2]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vt[3]  = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        vt[4]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vt[5]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vt[6]  = '{1'b1, 32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000};
        vt[7]  = '{1'b0, 32'h8000_0000, 32'd1,        64'h0000_0000_8000_0000};
        vt[8]  = '{1'b1, 32'h1234_5678, 32'd0,        64'h0000_0000_0000_0000};
        vt[9]  = '{1'b1, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB};
        vt[10] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vt[11] = '{1'b0, 32'd3,         32'd5,        64'h0000_0000_0000_000F};

        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset grant", gv, 0);
        chk("reset busy", bv, 0);
        chk("reset result_valid", rv, 0);
        chk("reset units_free", units_free, NU);
        chk("reset result", result[0], 0);
        rst_n = 1'b1;

        lock_req[0] = 1; lock_id[0] = 5;
        lock_req[1] = 1; lock_id[1] = 3;
        lock_req[2] = 1; lock_id[2] = 9;
        tick();
        chk("age first grants", gv, 8'h03);
        chk("age units_free full", units_free, 0);
        lock_id[0] = 16'h0100;
        tick();
        chk("age hold under id change", gv, 8'h03);
        lock_req[1] = 0;
        tick();
        chk("age release", gv, 8'h01);
        chk("age units_free after release", units_free, 1);
        tick();
        chk("age waiter granted", gv, 8'h05);
        chk("age units_free regranted", units_free, 0);
        idle();
        tick();
        chk("age all released", gv, 0);
        chk("age units_free all", units_free, NU);

        lock_req[0] = 1;
        tick();
        chk("wrap holder", gv, 8'h01);
        lock_req[4] = 1; lock_id[4] = 16'hFFFE;
        lock_req[2] = 1; lock_id[2] = 16'h0001;
        tick();
        chk("wrap winner", gv, 8'h11);
        idle();
        tick();

        op_valid[5] = 1;
        lock_req[3] = 1; lock_id[3] = 7;
        tick();
        chk("grant port3", gv, 8'h08);
        chk("ungranted op ignored", bv, 0);
        op_valid[5] = 0;
        for (int i = 0; i < 12; i++) begin
            op_valid[3]  = 1;
            op_signed[3] = vt[i].sgn;
            op_a[3]      = vt[i].a;
            op_b[3]      = vt[i].b;
            tick();
            chk("accept busy", bv, 8'h08);
            op_a[3] = 32'h5A5A_5A5A;
            tick();
            op_valid[3] = 0;
            n = 1;
            while (!rv[3] && n < 10) begin
                tick();
                n++;
            end
            chk("latency", n, L);
            chk("product", result[3], vt[i].exp);
            chk("busy clear at result", bv, 0);
            tick();
            chk("result pulse width", rv, 0);
        end

        chk("units_free one held", units_free, 1);
        op_valid[3] = 1; op_signed[3] = 0; op_a[3] = 32'd9; op_b[3] = 32'd9;
        tick();
        op_valid[3] = 0;
        chk("drop case busy", bv, 8'h08);
        lock_req[3] = 0;
        tick();
        chk("drop grant", gv, 0);
        chk("drop busy", bv, 0);
        chk("drop units_free", units_free, NU);
        lock_req[6] = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) chk("regrant after drop", gv, 8'h40);
            chk("no result after drop", rv, 0);
        end
        idle();
        tick();

        lock_req[0] = 1;
        tick();
        op_valid[0] = 1; op_a[0] = 32'd3; op_b[0] = 32'd4;
        tick();
        op_valid[0] = 0;
        tick();
        tick();
        flush = 1;
        lock_req[5] = 1;
        tick();
        chk("flush result suppressed", rv, 0);
        chk("flush grants", gv, 0);
        chk("flush busy", bv, 0);
        chk("flush units_free", units_free, NU);
        idle();
        tick();
        chk("flush no stray result", rv, 0);
        chk("flush no late grant", gv, 0);

        lock_req[0] = 1; lock_req[1] = 1;
        tick();
        chk("reset case grants", gv, 8'h03);
        op_valid[0] = 1; op_a[0] = 32'd6; op_b[0] = 32'd7;
        op_valid[1] = 1; op_a[1] = 32'd8; op_b[1] = 32'd9;
        tick();
        op_valid[0] = 0; op_valid[1] = 0;
        chk("reset case busy", bv, 8'h03);
        tick();
        rst_n = 0;
        tick();
        chk("midflight reset grant", gv, 0);
        chk("midflight reset busy", bv, 0);
        chk("midflight reset result_valid", rv, 0);
        chk("midflight reset units_free", units_free, NU);
        chk("midflight reset result0", result[0], 0);
        chk("midflight reset result1", result[1], 0);
        rst_n = 1;
        idle();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("no stray result after reset", rv, 0);
        end

        rst_n = 0;
        model_step();
        tick();
        rst_n = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_n = $urandom_range(0, 299) != 0;
            flush = $urandom_range(0, 39) == 0;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 7) == 0) lock_req[p] = !lock_req[p];
                if ($urandom_range(0, 3) == 0)
                    lock_id[p] = ($urandom_range(0, 3) == 0) ? IW'($urandom) : IW'($urandom_range(0, 7));
                op_valid[p]  = $urandom_range(0, 2) == 0;
                op_signed[p] = 1'($urandom_range(0, 1));
                op_a[p]      = pick_operand();
                op_b[p]      = pick_operand();
            end
            model_step();
            tick();
            nfree_exp = NU;
            for (int p = 0; p < NP; p++) begin
                eg[p] = m_g[p];
                eb[p] = m_busy[p];
                er[p] = e_rv[p];
                if (m_g[p]) nfree_exp--;
            end
            chk("rand grant", gv, eg);
            chk("rand busy", bv, eb);
            chk("rand result_valid", rv, er);
            chk("rand units_free", units_free, nfree_exp);
            for (int p = 0; p < NP; p++) if (e_rv[p]) chk("rand result", result[p], e_res[p]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
